mmio_sim_console: RTL

- Synthesisable successor to the testbench-only MMIO peeper. Decodes CPU MMIO accesses for halt, console output and a cycle watchdog.
- Generalises console output to NCH independent byte channels. Each channel has its own FIFO and drains over a valid/ready stream.
- Sits beside the data-memory path in the board top. In simulation, the bench consumes its outputs instead of probing CPU internals.

---
 rtl/mmio_sim_console_pkg.sv | 26 ++
 rtl/mmio_sim_console_if.sv | 21 ++
 rtl/mmio_sim_console_byte_fifo.sv | 53 +++++
 rtl/mmio_sim_console.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/mmio_sim_console_pkg.sv
// rtl/mmio_sim_console_pkg.sv - MMIO offsets and status layout shared by RTL, runtime and bench
package mmio_sim_console_pkg;

    localparam logic [31:0] OFS_HALT     = 32'h000;
    localparam logic [31:0] OFS_TX       = 32'h100;
    localparam logic [31:0] TX_STRIDE    = 32'h010;
    localparam logic [31:0] OFS_WDLIMIT  = 32'h200;
    localparam logic [31:0] OFS_CYCLE_LO = 32'h204;
    localparam logic [31:0] OFS_CYCLE_HI = 32'h208;

    // Bit positions inside the TXk status word
    localparam int ST_EMPTY    = 0;
    localparam int ST_FULL     = 1;
    localparam int ST_OVF      = 2;
    localparam int ST_FREE_LSB = 8;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_HALT,
        REG_TX,
        REG_WDLIMIT,
        REG_CYCLE_LO,
        REG_CYCLE_HI
    } reg_sel_e;

endpackage

// File: rtl/mmio_sim_console_if.sv
// rtl/mmio_sim_console_if.sv - CPU MMIO access bus between the core and the console block
interface mmio_sim_console_if;

    logic        mmio_oe;
    logic [3:0]  mmio_we;
    logic [31:0] mmio_addr;
    logic [31:0] mmio_wdata;
    logic [31:0] mmio_rdata;
    logic        mmio_rvalid;

    modport master (
        output mmio_oe, mmio_we, mmio_addr, mmio_wdata,
        input  mmio_rdata, mmio_rvalid
    );

    modport slave (
        input  mmio_oe, mmio_we, mmio_addr, mmio_wdata,
        output mmio_rdata, mmio_rvalid
    );

endinterface

// File: rtl/mmio_sim_console_byte_fifo.sv
// rtl/mmio_sim_console_byte_fifo.sv - show-ahead byte FIFO with wrap-bit pointers
module byte_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push_i,
    input  logic [7:0]             din_i,
    output logic                   full_o,
    input  logic                   pop_i,
    output logic [7:0]             dout_o,
    output logic                   empty_o,
    output logic [$clog2(DEPTH):0] count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [DEPTH];
    logic        do_push, do_pop;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign dout_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A pop frees the head slot in the same cycle, so a full FIFO may still push
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

endmodule

// File: rtl/mmio_sim_console.sv
// rtl/mmio_sim_console.sv - MMIO decode for halt, per-channel console FIFOs and cycle watchdog
module mmio_sim_console
    import mmio_sim_console_pkg::*;
#(
    parameter logic [31:0] BASE       = 32'hf000_0000,
    parameter int          NCH        = 2,
    parameter int          DEPTH      = 16,
    parameter logic [31:0] WD_DEFAULT = 32'd100000
) (
    input  logic               clk,
    input  logic               resetn,
    mmio_sim_console_if.slave  bus,
    output logic [NCH-1:0]     ch_valid,
    output logic [NCH*8-1:0]   ch_data,
    input  logic [NCH-1:0]     ch_ready,
    output logic               halted,
    output logic [31:0]        halt_code,
    output logic               wd_abort,
    output logic [63:0]        cycle
);

    localparam int          CW     = $clog2(DEPTH) + 1;
    localparam logic [31:0] TX_END = OFS_TX + TX_STRIDE * 32'(NCH);

    logic        halted_q, halted_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic        wd_abort_q, wd_abort_d;
    logic [31:0] wd_cnt_q, wd_cnt_d;
    logic [31:0] wd_limit_q, wd_limit_d;
    logic [63:0] cycle_q;
    logic [31:0] cycle_hi_q, cycle_hi_d;
    logic [31:0] rdata_q, rdata_d;
    logic        rvalid_q, rvalid_d;
    logic [NCH-1:0] ovf_q;

    logic [31:0] ofs;
    reg_sel_e    sel;
    logic [2:0]  tx_idx;
    logic        wr_en, rd_en, halt_wr, lim_wr, wd_run;
    logic [31:0] rd_word;
    logic [NCH-1:0] push_req, push, pop, drop;
    logic [31:0] tx_status [NCH];

    assign ofs = bus.mmio_addr - BASE;

    always_comb begin
        sel    = REG_NONE;
        tx_idx = ofs[6:4];
        if (ofs == OFS_HALT)                                        sel = REG_HALT;
        else if (ofs == OFS_WDLIMIT)                                sel = REG_WDLIMIT;
        else if (ofs == OFS_CYCLE_LO)                               sel = REG_CYCLE_LO;
        else if (ofs == OFS_CYCLE_HI)                               sel = REG_CYCLE_HI;
        else if (ofs >= OFS_TX && ofs < TX_END && ofs[3:0] == 4'h0) sel = REG_TX;
    end

    // Halt or watchdog abort freezes the register file against further writes
    assign wr_en   = bus.mmio_oe && (bus.mmio_we != 4'b0) && !halted_q && !wd_abort_q;
    assign rd_en   = bus.mmio_oe && (bus.mmio_we == 4'b0);
    assign halt_wr = wr_en && (sel == REG_HALT);
    assign lim_wr  = wr_en && (sel == REG_WDLIMIT);
    assign wd_run  = !halted_q && !wd_abort_q && (wd_limit_q != 32'd0);

    for (genvar k = 0; k < NCH; k++) begin : g_ch
        logic          full, empty;
        logic [7:0]    dout;
        logic [CW-1:0] count;
        logic [8:0]    free_raw;
        logic [7:0]    free_sat;

        byte_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk     (clk),
            .resetn  (resetn),
            .push_i  (push[k]),
            .din_i   (bus.mmio_wdata[7:0]),
            .full_o  (full),
            .pop_i   (pop[k]),
            .dout_o  (dout),
            .empty_o (empty),
            .count_o (count)
        );

        assign ch_valid[k]       = !empty;
        assign ch_data[8*k +: 8] = dout;
        assign pop[k]            = !empty && ch_ready[k];
        assign push_req[k]       = wr_en && (sel == REG_TX) && (tx_idx == 3'(k)) && bus.mmio_we[0];
        assign push[k]           = push_req[k] && (!full || ch_ready[k]);
        assign drop[k]           = push_req[k] && full && !ch_ready[k];
        assign free_raw          = 9'(DEPTH) - 9'(count);
        assign free_sat          = free_raw[8] ? 8'hff : free_raw[7:0];
        assign tx_status[k]      = {16'b0, free_sat, 5'b0, ovf_q[k], full, empty};
    end

    always_comb begin
        rd_word = '0;
        case (sel)
            REG_HALT:     rd_word = halt_code_q;
            REG_WDLIMIT:  rd_word = wd_limit_q;
            REG_CYCLE_LO: rd_word = cycle_q[31:0];
            REG_CYCLE_HI: rd_word = cycle_hi_q;
            REG_TX: begin
                for (int k = 0; k < NCH; k++) begin
                    if (tx_idx == 3'(k)) rd_word = tx_status[k];
                end
            end
            default:      rd_word = '0;
        endcase
    end

    always_comb begin
        halted_d    = halted_q;
        halt_code_d = halt_code_q;
        wd_abort_d  = wd_abort_q;
        wd_cnt_d    = wd_cnt_q;
        wd_limit_d  = wd_limit_q;
        cycle_hi_d  = cycle_hi_q;
        rdata_d     = rdata_q;
        rvalid_d    = rd_en;

        if (halt_wr) begin
            halted_d    = 1'b1;
            halt_code_d = bus.mmio_wdata;
        end
        // A halt landing on the expiry cycle takes precedence over the abort
        if (lim_wr) begin
            wd_limit_d = bus.mmio_wdata;
            wd_cnt_d   = '0;
        end else if (wd_run) begin
            wd_cnt_d = wd_cnt_q + 32'd1;
            if (wd_cnt_q == wd_limit_q - 32'd1 && !halt_wr) wd_abort_d = 1'b1;
        end
        if (rd_en) begin
            rdata_d = rd_word;
            if (sel == REG_CYCLE_LO) cycle_hi_d = cycle_q[63:32];
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            halted_q    <= 1'b0;
            halt_code_q <= '0;
            wd_abort_q  <= 1'b0;
            wd_cnt_q    <= '0;
            wd_limit_q  <= WD_DEFAULT;
            cycle_q     <= '0;
            cycle_hi_q  <= '0;
            rdata_q     <= '0;
            rvalid_q    <= 1'b0;
            ovf_q       <= '0;
        end else begin
            halted_q    <= halted_d;
            halt_code_q <= halt_code_d;
            wd_abort_q  <= wd_abort_d;
            wd_cnt_q    <= wd_cnt_d;
            wd_limit_q  <= wd_limit_d;
            cycle_q     <= cycle_q + 64'd1;
            cycle_hi_q  <= cycle_hi_d;
            rdata_q     <= rdata_d;
            rvalid_q    <= rvalid_d;
            ovf_q       <= ovf_q | drop;
        end
    end

    assign bus.mmio_rdata  = rdata_q;
    assign bus.mmio_rvalid = rvalid_q;
    assign halted          = halted_q;
    assign halt_code       = halt_code_q;
    assign wd_abort        = wd_abort_q;
    assign cycle           = cycle_q;

endmodule
